// File: rtl/emib_flash_arbiter.sv
// emib_flash_arbiter: shares the EMIB flash controller between the boot-load and save requesters.
// Revision: 1.0 - initial release
`default_nettype none

module emib_flash_arbiter #(
  parameter int                ADDR_W  = 16,
  parameter logic [ADDR_W-1:0] RD_ADDR = 16'h0000,
  parameter logic [ADDR_W-1:0] RD_LEN  = 16'h0B00,
  parameter int                TMO_W   = 20,
  parameter logic [TMO_W-1:0]  TMO_CYC = 20'hFFFFF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rd_irq,
  output logic              o_rd_en,
  output logic              o_rd_done,
  input  logic              i_wr_irq,
  input  logic [ADDR_W-1:0] i_wr_offset,
  input  logic [ADDR_W-1:0] i_wr_len,
  output logic              o_wr_en,
  output logic              o_wr_done,
  output logic              o_flash_start,
  output logic              o_flash_op,
  output logic [ADDR_W-1:0] o_flash_addr,
  output logic [ADDR_W-1:0] o_flash_len,
  output logic              o_flash_abort,
  input  logic              i_flash_done,
  output logic              o_busy,
  output logic              o_timeout,
  output logic              o_boot_ok,
  output logic              o_boot_fail
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic [TMO_W-1:0] TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_CYC - TMO_ONE;

  state_t            state_q, state_d;
  logic              op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [TMO_W-1:0]  cnt_q, cnt_d;
  logic              rd_armed_q, rd_armed_d;
  logic              wr_armed_q, wr_armed_d;
  logic              start_q, start_d;
  logic              rd_en_q, rd_en_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_done_q, rd_done_d;
  logic              wr_done_q, wr_done_d;
  logic              abort_q, abort_d;
  logic              busy_q, busy_d;
  logic              boot_ok_q, boot_ok_d;
  logic              boot_fail_q, boot_fail_d;
  logic              rd_elig, wr_elig;

  // Saves are held off until the boot load has resolved one way or the other.
  assign rd_elig = i_rd_irq & rd_armed_q;
  assign wr_elig = i_wr_irq & wr_armed_q & (boot_ok_q | boot_fail_q);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    rd_armed_d  = rd_armed_q | ~i_rd_irq;
    wr_armed_d  = wr_armed_q | ~i_wr_irq;
    start_d     = 1'b0;
    rd_en_d     = 1'b0;
    wr_en_d     = 1'b0;
    rd_done_d   = 1'b0;
    wr_done_d   = 1'b0;
    abort_d     = 1'b0;
    boot_ok_d   = boot_ok_q;
    boot_fail_d = boot_fail_q;

    case (state_q)
      ST_IDLE: begin
        if (rd_elig) begin
          state_d    = ST_START;
          op_d       = 1'b0;
          addr_d     = RD_ADDR;
          len_d      = RD_LEN;
          start_d    = 1'b1;
          rd_en_d    = 1'b1;
          rd_armed_d = 1'b0;
        end else if (wr_elig) begin
          state_d    = ST_START;
          op_d       = 1'b1;
          addr_d     = i_wr_offset;
          len_d      = i_wr_len;
          start_d    = 1'b1;
          wr_en_d    = 1'b1;
          wr_armed_d = 1'b0;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + TMO_ONE;
        // Completion takes precedence over an expiry landing in the same cycle.
        if (i_flash_done) begin
          state_d = ST_IDLE;
          if (op_q) begin
            wr_done_d = 1'b1;
          end else begin
            rd_done_d = 1'b1;
            boot_ok_d = 1'b1;
          end
        end else if (cnt_q == TMO_LAST) begin
          state_d = ST_IDLE;
          abort_d = 1'b1;
          if (!op_q) begin
            boot_fail_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      op_q        <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      rd_armed_q  <= 1'b1;
      wr_armed_q  <= 1'b1;
      start_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_done_q   <= 1'b0;
      wr_done_q   <= 1'b0;
      abort_q     <= 1'b0;
      busy_q      <= 1'b0;
      boot_ok_q   <= 1'b0;
      boot_fail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      rd_armed_q  <= rd_armed_d;
      wr_armed_q  <= wr_armed_d;
      start_q     <= start_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      rd_done_q   <= rd_done_d;
      wr_done_q   <= wr_done_d;
      abort_q     <= abort_d;
      busy_q      <= busy_d;
      boot_ok_q   <= boot_ok_d;
      boot_fail_q <= boot_fail_d;
    end
  end

  assign o_rd_en       = rd_en_q;
  assign o_rd_done     = rd_done_q;
  assign o_wr_en       = wr_en_q;
  assign o_wr_done     = wr_done_q;
  assign o_flash_start = start_q;
  assign o_flash_op    = op_q;
  assign o_flash_addr  = addr_q;
  assign o_flash_len   = len_q;
  assign o_flash_abort = abort_q;
  assign o_busy        = busy_q;
  assign o_timeout     = abort_q;
  assign o_boot_ok     = boot_ok_q;
  assign o_boot_fail   = boot_fail_q;

endmodule

`default_nettype wire
